// File: rtl/safe_control_fsm.sv
// Master control FSM of the digital safe: password entry/check, chances, lockout and open timers.
// Optional password change (SET_PW state + writable password) is enabled by `SAFE_PW_CHANGE_EN.
module safe_control_fsm #(
  parameter logic [15:0] PW_INIT    = 16'h1234,
  parameter int          MAX_CHANCE = 3,
  parameter int          LOCK_SEC   = 30,
  parameter int          OPEN_SEC   = 10,
  parameter int          FAIL_SEC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  state,
  output logic [3:0]  chance_count,
  output logic [15:0] input_data,
  output logic [5:0]  timer_min,
  output logic [5:0]  timer_sec,
  output logic        servo_open
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INPUT   = 4'd1,
    S_CHECK   = 4'd2,
    S_OPEN    = 4'd3,
    S_FAIL    = 4'd4,
    S_LOCKOUT = 4'd5,
    S_SET_PW  = 4'd6
  } state_e;

  localparam logic [3:0] CHANCE_INIT = 4'(MAX_CHANCE);
  localparam logic [5:0] OPEN_M = 6'(OPEN_SEC / 60);
  localparam logic [5:0] OPEN_S = 6'(OPEN_SEC % 60);
  localparam logic [5:0] FAIL_M = 6'(FAIL_SEC / 60);
  localparam logic [5:0] FAIL_S = 6'(FAIL_SEC % 60);
  localparam logic [5:0] LOCK_M = 6'(LOCK_SEC / 60);
  localparam logic [5:0] LOCK_S = 6'(LOCK_SEC % 60);

  // Key and tick events are registered once, so every event acts one edge after it is sampled.
  logic        key_vld_q;
  logic [3:0]  key_q;
  logic        tick_q;

  state_e      state_q, state_d;
  logic [3:0]  chance_q, chance_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic        servo_q;
  logic [15:0] pw_val;

`ifdef SAFE_PW_CHANGE_EN
  logic [15:0] pw_q, pw_d;
  assign pw_val = pw_q;
`else
  assign pw_val = PW_INIT;
`endif

  logic        is_digit, is_star, is_hash;
  logic        tmr_zero;
  logic [5:0]  dec_min, dec_sec;
  logic        to_idle;

  assign is_digit = key_vld_q && (key_q <= 4'd9);
  assign is_star  = key_vld_q && (key_q == 4'hA);
  assign is_hash  = key_vld_q && (key_q == 4'hB);
  assign tmr_zero = (min_q == 6'd0) && (sec_q == 6'd0);

  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q != 6'd0) begin
      dec_sec = sec_q - 6'd1;
    end else if (min_q != 6'd0) begin
      dec_min = min_q - 6'd1;
      dec_sec = 6'd59;
    end
  end

  always_comb begin
    state_d  = state_q;
    chance_d = chance_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    sec_d    = sec_q;
    to_idle  = 1'b0;
`ifdef SAFE_PW_CHANGE_EN
    pw_d     = pw_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        min_d = 6'd0;
        sec_d = 6'd0;
        if (is_digit) begin
          data_d  = {12'hFFF, key_q};
          cnt_d   = 3'd1;
          state_d = S_INPUT;
        end
      end

      S_INPUT: begin
        if (is_digit && (cnt_q < 3'd4)) begin
          data_d = {data_q[11:0], key_q};
          cnt_d  = cnt_q + 3'd1;
        end else if (is_star) begin
          to_idle = 1'b1;
        end else if (is_hash && (cnt_q == 3'd4)) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (data_q == pw_val) begin
          state_d  = S_OPEN;
          chance_d = CHANCE_INIT;
          min_d    = OPEN_M;
          sec_d    = OPEN_S;
        end else begin
          chance_d = chance_q - 4'd1;
          if (chance_q == 4'd1) begin
            state_d = S_LOCKOUT;
            min_d   = LOCK_M;
            sec_d   = LOCK_S;
          end else begin
            state_d = S_FAIL;
            min_d   = FAIL_M;
            sec_d   = FAIL_S;
          end
        end
      end

      S_OPEN: begin
        // A key that causes a transition beats both expiry and a coincident tick.
        if (is_hash) begin
          to_idle = 1'b1;
`ifdef SAFE_PW_CHANGE_EN
        end else if (is_star) begin
          state_d = S_SET_PW;
          data_d  = 16'hFFFF;
          cnt_d   = 3'd0;
          min_d   = 6'd0;
          sec_d   = 6'd0;
`endif
        end else if (tmr_zero) begin
          to_idle = 1'b1;
        end else if (tick_q) begin
          min_d = dec_min;
          sec_d = dec_sec;
        end
      end

      S_FAIL: begin
        if (tmr_zero) begin
          to_idle = 1'b1;
        end else if (tick_q) begin
          min_d = dec_min;
          sec_d = dec_sec;
        end
      end

      S_LOCKOUT: begin
        if (tmr_zero) begin
          to_idle  = 1'b1;
          chance_d = CHANCE_INIT;
        end else if (tick_q) begin
          min_d = dec_min;
          sec_d = dec_sec;
        end
      end

`ifdef SAFE_PW_CHANGE_EN
      S_SET_PW: begin
        if (is_digit && (cnt_q < 3'd4)) begin
          data_d = {data_q[11:0], key_q};
          cnt_d  = cnt_q + 3'd1;
        end else if (is_star) begin
          data_d = 16'hFFFF;
          cnt_d  = 3'd0;
        end else if (is_hash && (cnt_q == 3'd4)) begin
          pw_d    = data_q;
          to_idle = 1'b1;
        end
      end
`endif

      default: begin
        to_idle = 1'b1;
      end
    endcase

    if (to_idle) begin
      state_d = S_IDLE;
      data_d  = 16'hFFFF;
      cnt_d   = 3'd0;
      min_d   = 6'd0;
      sec_d   = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_vld_q <= 1'b0;
      key_q     <= 4'd0;
      tick_q    <= 1'b0;
      state_q   <= S_IDLE;
      chance_q  <= CHANCE_INIT;
      data_q    <= 16'hFFFF;
      cnt_q     <= 3'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      servo_q   <= 1'b0;
`ifdef SAFE_PW_CHANGE_EN
      pw_q      <= PW_INIT;
`endif
    end else begin
      key_vld_q <= key_valid;
      key_q     <= key_code;
      tick_q    <= tick_1hz;
      state_q   <= state_d;
      chance_q  <= chance_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      servo_q   <= (state_d == S_OPEN);
`ifdef SAFE_PW_CHANGE_EN
      pw_q      <= pw_d;
`endif
    end
  end

  assign state        = state_q;
  assign chance_count = chance_q;
  assign input_data   = data_q;
  assign timer_min    = min_q;
  assign timer_sec    = sec_q;
  assign servo_open   = servo_q;

endmodule

// File: tb/tb_safe_control_fsm.sv
// Directed bench for safe_control_fsm: expected snapshots are queued with each stimulus
// and popped/compared once the DUT has had time to respond.
module tb_safe_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  state;
  logic [3:0]  chance_count;
  logic [15:0] input_data;
  logic [5:0]  timer_min;
  logic [5:0]  timer_sec;
  logic        servo_open;

  safe_control_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .state        (state),
    .chance_count (chance_count),
    .input_data   (input_data),
    .timer_min    (timer_min),
    .timer_sec    (timer_sec),
    .servo_open   (servo_open)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  ch;
    logic [15:0] dat;
    logic [5:0]  mn;
    logic [5:0]  sc;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = 4'd0;
    step();
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic enter4(input logic [15:0] pw);
    press(pw[15:12]);
    press(pw[11:8]);
    press(pw[7:4]);
    press(pw[3:0]);
  endtask

  task automatic push_exp(input string tag, input logic [3:0] st, input logic [3:0] ch,
                          input logic [15:0] dat, input logic [5:0] mn, input logic [5:0] sc);
    exp_t e;
    e.st = st; e.ch = ch; e.dat = dat; e.mn = mn; e.sc = sc;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
      $error("%s.%s", tag, fld);
    end
  endtask

  task automatic chk();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard observed=empty expected=entry");
      $error("scoreboard empty");
    end else begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      cmp(t, "state",  16'(state),        16'(e.st));
      cmp(t, "chance", 16'(chance_count), 16'(e.ch));
      cmp(t, "data",   input_data,        e.dat);
      cmp(t, "min",    16'(timer_min),    16'(e.mn));
      cmp(t, "sec",    16'(timer_sec),    16'(e.sc));
      cmp(t, "servo",  16'(servo_open),   16'(e.st == 4'd3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    step(); step();
    push_exp("reset", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); chk();
    rst = 1'b0;

    // correct password, open, timeout
    push_exp("digit1", 4'd1, 4'd3, 16'hFFF1, 6'd0, 6'd0); press(4'd1); chk();
    press(4'd2); press(4'd3);
    push_exp("digit4", 4'd1, 4'd3, 16'h1234, 6'd0, 6'd0); press(4'd4); chk();
    push_exp("check", 4'd2, 4'd3, 16'h1234, 6'd0, 6'd0); press(4'hB); chk();
    push_exp("open", 4'd3, 4'd3, 16'h1234, 6'd0, 6'd10); step(); chk();
    push_exp("tick1", 4'd3, 4'd3, 16'h1234, 6'd0, 6'd9); tick(); chk();
    push_exp("open_0000", 4'd3, 4'd3, 16'h1234, 6'd0, 6'd0); repeat (9) tick(); chk();
    push_exp("open_tmo", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); step(); chk();

    // three wrong attempts into lockout
    for (int a = 1; a <= 3; a++) begin
      enter4(16'h9999);
      push_exp("bad_check", 4'd2, 4'(4 - a), 16'h9999, 6'd0, 6'd0); press(4'hB); chk();
      if (a < 3) begin
        push_exp("fail", 4'd4, 4'(3 - a), 16'h9999, 6'd0, 6'd2); step(); chk();
        tick(); tick();
        push_exp("fail_0000", 4'd4, 4'(3 - a), 16'h9999, 6'd0, 6'd0); chk();
        push_exp("fail_exit", 4'd0, 4'(3 - a), 16'hFFFF, 6'd0, 6'd0); step(); chk();
      end else begin
        push_exp("lockout", 4'd5, 4'd0, 16'h9999, 6'd0, 6'd30); step(); chk();
      end
    end
    push_exp("lock_key_ign", 4'd5, 4'd0, 16'h9999, 6'd0, 6'd30); press(4'd5); chk();
    push_exp("lock_tick", 4'd5, 4'd0, 16'h9999, 6'd0, 6'd29); tick(); chk();
    push_exp("lock_0000", 4'd5, 4'd0, 16'h9999, 6'd0, 6'd0); repeat (29) tick(); chk();
    push_exp("lock_exit", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); step(); chk();

    // fifth digit ignored, # leaves OPEN
    enter4(16'h1234);
    push_exp("digit5_ign", 4'd1, 4'd3, 16'h1234, 6'd0, 6'd0); press(4'd5); chk();
    press(4'hB);
    push_exp("open2", 4'd3, 4'd3, 16'h1234, 6'd0, 6'd10); step(); chk();
`ifndef SAFE_PW_CHANGE_EN
    push_exp("star_ign", 4'd3, 4'd3, 16'h1234, 6'd0, 6'd10); press(4'hA); chk();
`endif
    push_exp("hash_exit", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); press(4'hB); chk();

    // short entry: # ignored, * clears
    press(4'd1);
    push_exp("short_12", 4'd1, 4'd3, 16'hFF12, 6'd0, 6'd0); press(4'd2); chk();
    push_exp("short_hash", 4'd1, 4'd3, 16'hFF12, 6'd0, 6'd0); press(4'hB); chk();
    push_exp("star_clr", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); press(4'hA); chk();

    // # and tick in the same cycle while OPEN
    enter4(16'h1234); press(4'hB);
    push_exp("open3", 4'd3, 4'd3, 16'h1234, 6'd0, 6'd10); step(); chk();
    key_valid = 1'b1; key_code = 4'hB; tick_1hz = 1'b1;
    step();
    key_valid = 1'b0; key_code = 4'd0; tick_1hz = 1'b0;
    push_exp("simul", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); step(); chk();

`ifdef SAFE_PW_CHANGE_EN
    enter4(16'h1234); press(4'hB); step();
    push_exp("set_pw", 4'd6, 4'd3, 16'hFFFF, 6'd0, 6'd0); press(4'hA); chk();
    press(4'd5); press(4'd6); press(4'd7);
    push_exp("set_pw_dig", 4'd6, 4'd3, 16'h5678, 6'd0, 6'd0); press(4'd8); chk();
    push_exp("set_pw_done", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); press(4'hB); chk();
    enter4(16'h1234); press(4'hB);
    push_exp("old_pw_fail", 4'd4, 4'd2, 16'h1234, 6'd0, 6'd2); step(); chk();
    tick(); tick(); step();
    enter4(16'h5678); press(4'hB);
    push_exp("new_pw_open", 4'd3, 4'd3, 16'h5678, 6'd0, 6'd10); step(); chk();
    press(4'hB);
`endif

    // reset while in LOCKOUT restores everything, password included
    for (int a = 1; a <= 3; a++) begin
      enter4(16'h9999); press(4'hB); step();
      if (a < 3) begin
        tick(); tick(); step();
      end
    end
    push_exp("lockout2", 4'd5, 4'd0, 16'h9999, 6'd0, 6'd30); chk();
    rst = 1'b1;
    push_exp("mid_reset", 4'd0, 4'd3, 16'hFFFF, 6'd0, 6'd0); step(); chk();
    rst = 1'b0;
    enter4(16'h1234); press(4'hB);
    push_exp("pw_restored", 4'd3, 4'd3, 16'h1234, 6'd0, 6'd10); step(); chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
